// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - UART boot loader that writes a received program into instruction memory
// Purpose : receives 8N1 bytes on rx_i and parses the packet A5, N, 4*N data bytes
//           (little-endian words), plus an optional XOR checksum byte. Each word is
//           written to instruction memory, and the CPU is held in reset while loading.
// Ports   : clk_i      - system clock
//           rst_i      - asynchronous active-high reset
//           rx_i       - UART serial input (idle high, asynchronous to clk_i)
//           we_o       - one-cycle instruction-memory write strobe
//           wraddr_o   - word address of the write
//           wrdata_o   - instruction word being written
//           cpu_hold_o - high while a load is in progress
//           done_o     - high after a successful load
//           err_o      - sticky error flag for the last load attempt
// Option  : define IMEM_LOADER_CHECKSUM_EN to require the checksum byte after the data.
module imem_loader #(
    parameter int CLKS_PER_BIT = 434,
    parameter int ADDR_W       = 6
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rx_i,
    output logic              we_o,
    output logic [ADDR_W-1:0] wraddr_o,
    output logic [31:0]       wrdata_o,
    output logic              cpu_hold_o,
    output logic              done_o,
    output logic              err_o
);
    localparam int HALF_BIT  = CLKS_PER_BIT / 2;
    localparam int CNT_W     = $clog2(CLKS_PER_BIT + 1);
    localparam int WCNT_W    = ADDR_W + 1;
    localparam int MAX_WORDS = 1 << ADDR_W;

    // ---------------- UART receiver ----------------
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t        rx_state_q;
    logic             rx_meta_q, rx_sync_q, rx_prev_q;
    logic [CNT_W-1:0] rx_cnt_q;
    logic [2:0]       rx_bit_q;
    logic [7:0]       rx_shift_q;
    logic             rx_valid_q;   // byte in rx_shift_q is valid this cycle
    logic             rx_ferr_q;    // framing error seen on the last stop bit

    // Synchronizer flops reset to the idle-high level, so no false start edge
    // can be seen in the first two cycles after reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_valid_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            rx_meta_q  <= rx_i;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            rx_valid_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
            case (rx_state_q)
                RX_IDLE: begin
                    if (rx_prev_q && !rx_sync_q) begin
                        rx_state_q <= RX_START;
                        rx_cnt_q   <= '0;
                    end
                end
                RX_START: begin
                    if (rx_cnt_q == CNT_W'(HALF_BIT - 1)) begin
                        // Line back high at mid start bit: treat as a glitch.
                        rx_cnt_q   <= '0;
                        rx_bit_q   <= '0;
                        rx_state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                        rx_cnt_q   <= '0;
                        rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
                        rx_bit_q   <= rx_bit_q + 3'd1;
                        if (rx_bit_q == 3'd7) begin
                            rx_state_q <= RX_STOP;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                        rx_cnt_q   <= '0;
                        rx_state_q <= RX_IDLE;
                        rx_valid_q <= rx_sync_q;
                        rx_ferr_q  <= !rx_sync_q;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    // ---------------- Protocol FSM ----------------
    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHK,
`endif
        S_DONE
    } state_t;

    state_t            state_q;
    logic              we_q, hold_q, done_q, err_q;
    logic [ADDR_W-1:0] wraddr_q;
    logic [31:0]       wrdata_q;
    logic [WCNT_W-1:0] words_left_q;
    logic [1:0]        byte_idx_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        csum_q;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            we_q         <= 1'b0;
            hold_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            wraddr_q     <= '0;
            wrdata_q     <= '0;
            words_left_q <= '0;
            byte_idx_q   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            we_q <= 1'b0;
            // Address advances in the cycle following each write strobe.
            if (we_q) begin
                wraddr_q <= wraddr_q + 1'b1;
            end
            if (rx_ferr_q) begin
                // A broken frame aborts any load; a half-built word is never written.
                state_q <= S_IDLE;
                hold_q  <= 1'b0;
                err_q   <= 1'b1;
            end else begin
                case (state_q)
                    S_IDLE, S_DONE: begin
                        if (rx_valid_q && rx_shift_q == 8'hA5) begin
                            state_q  <= S_LEN;
                            hold_q   <= 1'b1;
                            done_q   <= 1'b0;
                            err_q    <= 1'b0;
                            wraddr_q <= '0;
                        end
                    end
                    S_LEN: begin
                        if (rx_valid_q) begin
                            if (rx_shift_q == 8'd0 || int'(rx_shift_q) > MAX_WORDS) begin
                                state_q <= S_IDLE;
                                hold_q  <= 1'b0;
                                err_q   <= 1'b1;
                            end else begin
                                state_q      <= S_DATA;
                                words_left_q <= WCNT_W'(rx_shift_q);
                                byte_idx_q   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                                csum_q       <= '0;
`endif
                            end
                        end
                    end
                    S_DATA: begin
                        if (rx_valid_q) begin
                            // Shift in from the top so the first byte ends up in [7:0].
                            wrdata_q   <= {rx_shift_q, wrdata_q[31:8]};
                            byte_idx_q <= byte_idx_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                            csum_q     <= csum_q ^ rx_shift_q;
`endif
                            if (byte_idx_q == 2'd3) begin
                                we_q <= 1'b1;
                            end
                        end else if (we_q) begin
                            words_left_q <= words_left_q - 1'b1;
                            if (words_left_q == WCNT_W'(1)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                                state_q <= S_CHK;
`else
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                                hold_q  <= 1'b0;
`endif
                            end
                        end
                    end
`ifdef IMEM_LOADER_CHECKSUM_EN
                    S_CHK: begin
                        if (rx_valid_q) begin
                            hold_q <= 1'b0;
                            if (rx_shift_q == csum_q) begin
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= S_IDLE;
                                err_q   <= 1'b1;
                            end
                        end
                    end
`endif
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign we_o       = we_q;
    assign wraddr_o   = wraddr_q;
    assign wrdata_o   = wrdata_q;
    assign cpu_hold_o = hold_q;
    assign done_o     = done_q;
    assign err_o      = err_q;

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 434, clock cycles per UART bit (50 MHz / 115200).
REQ-002 The block SHALL have parameter ADDR_W, default 6, instruction-memory word-address width (64 words, indexed by pc[7:2]).
REQ-003 The block SHALL have port clk_i  input  1  system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port rx_i  input  1  UART serial input, 8N1, idle high, asynchronous to clk_i.
REQ-006 The block SHALL have port we_o  output  1  instruction-memory write strobe, one-cycle pulse.
REQ-007 The block SHALL have port wraddr_o  output  ADDR_W  instruction-memory word address.
REQ-008 The block SHALL have port wrdata_o  output  32  instruction word to write.
REQ-009 The block SHALL have port cpu_hold_o  output  1  high while a load is in progress; holds the CPU in reset.
REQ-010 The block SHALL have port done_o  output  1  high after a load completes successfully.
REQ-011 The block SHALL have port err_o  output  1  sticky error flag for the last load attempt.

Function
REQ-012 rx_i SHALL pass through a 2-flop synchronizer before any use.
REQ-013 The receiver SHALL detect the start bit on a synchronized high-to-low transition and re-sample it after CLKS_PER_BIT/2 cycles; a high level at that point SHALL abort reception silently (glitch).
REQ-014 Data bits SHALL be sampled every CLKS_PER_BIT cycles after the start-bit midpoint, LSB first, followed by the stop-bit sample.
REQ-015 A stop-bit sample of 0 SHALL be a framing error: discard the byte, set err_o, return the FSM to IDLE.
REQ-016 Each valid byte SHALL be delivered to the protocol FSM one cycle after the stop-bit sample.
REQ-017 The protocol FSM SHALL have states IDLE, LEN, DATA, CHK (only with CHECKSUM_EN), DONE.
REQ-018 In IDLE and DONE, byte 0xA5 SHALL move to LEN, set cpu_hold_o, and clear done_o, err_o and wraddr_o; any other byte SHALL be ignored.
REQ-019 In LEN, byte N with 1 <= N <= 2^ADDR_W SHALL be latched as the word count and move to DATA; N = 0 or N > 2^ADDR_W SHALL set err_o, clear cpu_hold_o and return to IDLE.
REQ-020 In DATA, bytes SHALL be assembled little-endian: wrdata_o = {b3,b2,b1,b0}.
REQ-021 we_o SHALL pulse for exactly one cycle, starting the cycle after the 4th byte of a word is delivered, with wraddr_o and wrdata_o stable during the pulse.
REQ-022 wraddr_o SHALL increment by 1 in the cycle after each we_o pulse, with modulo 2^ADDR_W wrap.
REQ-023 After the N-th word's we_o pulse, the FSM SHALL go to CHK, or to DONE when checksum checking is compiled out.
REQ-024 Entering DONE SHALL set done_o and clear cpu_hold_o in the same cycle.
REQ-025 A framing error during LEN, DATA or CHK SHALL abort the load: no further we_o, cpu_hold_o cleared, err_o set, FSM to IDLE.
REQ-026 A load aborted mid-word SHALL leave the partially assembled word unwritten.

Reset
REQ-027 While rst_i is high, all outputs SHALL be 0: we_o, wraddr_o, wrdata_o, cpu_hold_o, done_o, err_o.
REQ-028 Reset SHALL return the receiver to idle and the FSM to IDLE, discarding any byte in flight, including during a load.
REQ-029 The first valid start bit SHALL be accepted no earlier than 2 cycles after rst_i deasserts.

Configuration
REQ-030 With macro IMEM_LOADER_CHECKSUM_EN defined, the block SHALL expect one byte after the data in state CHK, equal to the XOR of all 4N data bytes.
REQ-031 With IMEM_LOADER_CHECKSUM_EN defined, a matching checksum SHALL enter DONE; a mismatch SHALL set err_o, clear cpu_hold_o and go to IDLE, with words already written left in memory.
REQ-032 Without IMEM_LOADER_CHECKSUM_EN, CHK SHALL not exist and no checksum byte SHALL be consumed.

Verification
REQ-033 The bench SHALL cover: send A5,01,13,00,00,00 (plus checksum 13 with the macro) -> one we_o with wraddr_o=0 and wrdata_o=0x00000013; then done_o=1 and cpu_hold_o=0.
REQ-034 The bench SHALL cover: send A5,40 and then 256 bytes -> 64 we_o pulses at addresses 0..63, wraddr_o wraps to 0, done_o=1.
REQ-035 The bench SHALL cover: send A5,00 -> err_o=1, no we_o, cpu_hold_o=0; then send A5 -> err_o clears.
REQ-036 The bench SHALL cover: send A5,02 and 4 bytes, then a byte with stop bit 0 -> exactly one we_o, then err_o=1 and cpu_hold_o=0.
REQ-037 The bench SHALL cover: a low glitch on rx_i shorter than CLKS_PER_BIT/2 -> no byte received; assert rst_i mid-DATA -> all outputs 0 immediately.
REQ-038 The bench SHALL cover, with the macro defined: send A5,01,13,00,00,00,FF -> we_o pulses once, then err_o=1 and done_o=0.
